// File: rtl/parzen_window_gen.sv
// Streams one window of L = 2^LEN_POW2 coefficients per frame (rectangular,
// triangular or Parzen) as a valid/ready stream with index and last flag.
module parzen_window_gen #(
  parameter int LEN_POW2  = 10,
  parameter int FRAC_BITS = 16,
  parameter int OUT_BITS  = FRAC_BITS + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                continuous,
  input  logic                stop,
  output logic [OUT_BITS-1:0] out_data,
  output logic [LEN_POW2-1:0] out_index,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  localparam int W  = FRAC_BITS + 1;
  localparam int XW = W + 4;
  localparam int SH = FRAC_BITS - (LEN_POW2 - 1);

  localparam logic [W-1:0]        ONE     = W'(1) << FRAC_BITS;
  localparam logic [LEN_POW2-1:0] K_LAST  = '1;
  localparam logic [LEN_POW2-1:0] K_HALF  = LEN_POW2'(1) << (LEN_POW2 - 1);
  localparam logic [LEN_POW2-1:0] K_QUART = LEN_POW2'(1) << (LEN_POW2 - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [LEN_POW2-1:0] k;
  logic [1:0]          mode_r;
  logic                cont_r;
  logic                stop_r;

  // Handshake: a sample transfers on any clock edge where out_valid && out_ready.
  // While out_valid && !out_ready the k counter and every pipeline stage hold,
  // so out_data/out_index/out_last stay stable and out_valid cannot drop.
  logic en;
  logic issue;
  logic stop_seen;
  logic xfer_last;

  assign en        = !out_valid || out_ready;
  assign issue     = (state == S_RUN);
  assign stop_seen = stop_r || stop;
  assign xfer_last = out_valid && out_ready && out_last;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k      <= '0;
      mode_r <= 2'd0;
      cont_r <= 1'b0;
      stop_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            k      <= '0;
            mode_r <= mode;
            cont_r <= continuous;
            stop_r <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) stop_r <= 1'b1;
          if (en) begin
            if (k == K_LAST) begin
              k <= '0;
              if (!(cont_r && !stop_seen)) state <= S_DRAIN;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (xfer_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fixed-point multiply, floor-truncated back to FRAC_BITS; operands lie in [0, 1.0].
  function automatic logic [W-1:0] mulq(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(p >> FRAC_BITS);
  endfunction

  // Stage 1 inputs: a = |k - H|, b = a/H exactly, and which Parzen segment applies.
  logic [LEN_POW2-1:0] a_c;
  logic [W-1:0]        b_c;
  logic                hi_c;

  always_comb begin
    a_c  = (k >= K_HALF) ? (k - K_HALF) : (K_HALF - k);
    b_c  = W'(a_c) << SH;
    hi_c = (a_c > K_QUART);
  end

  logic                s1_v;
  logic [LEN_POW2-1:0] s1_k;
  logic [W-1:0]        s1_b;
  logic [W-1:0]        s1_c;
  logic                s1_hi;

  logic [W-1:0] b2_c;
  logic [W-1:0] b3_c;
  logic [W-1:0] c3_c;

  assign b2_c = mulq(s1_b, s1_b);
  assign b3_c = mulq(b2_c, s1_b);
  assign c3_c = mulq(mulq(s1_c, s1_c), s1_c);

  logic                s2_v;
  logic [LEN_POW2-1:0] s2_k;
  logic [W-1:0]        s2_b2;
  logic [W-1:0]        s2_b3;
  logic [W-1:0]        s2_c;
  logic [W-1:0]        s2_c3;
  logic                s2_hi;

  logic signed [XW-1:0] one_x;
  logic signed [XW-1:0] b2_x;
  logic signed [XW-1:0] b3_x;
  logic signed [XW-1:0] c_x;
  logic signed [XW-1:0] c3_x;
  logic signed [XW-1:0] w_x;
  logic [W-1:0]         w_q;

  assign one_x = $signed(XW'(ONE));
  assign b2_x  = $signed(XW'(s2_b2));
  assign b3_x  = $signed(XW'(s2_b3));
  assign c_x   = $signed(XW'(s2_c));
  assign c3_x  = $signed(XW'(s2_c3));

  // Polynomial select and clamp; the Parzen inner segment is evaluated as
  // 1 + 6b^3 - 6b^2 in a signed word wide enough for the intermediate terms.
  always_comb begin
    w_x = one_x;
    case (mode_r)
      2'd0:    w_x = one_x;
      2'd1:    w_x = c_x;
      default: w_x = s2_hi ? (c3_x <<< 1)
                           : (one_x + (b3_x <<< 2) + (b3_x <<< 1)
                                    - (b2_x <<< 2) - (b2_x <<< 1));
    endcase
    if (w_x[XW-1])         w_q = '0;
    else if (w_x > one_x)  w_q = ONE;
    else                   w_q = w_x[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_k      <= '0;
      s1_b      <= '0;
      s1_c      <= '0;
      s1_hi     <= 1'b0;
      s2_v      <= 1'b0;
      s2_k      <= '0;
      s2_b2     <= '0;
      s2_b3     <= '0;
      s2_c      <= '0;
      s2_c3     <= '0;
      s2_hi     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      s1_v      <= issue;
      s1_k      <= k;
      s1_b      <= b_c;
      s1_c      <= ONE - b_c;
      s1_hi     <= hi_c;
      s2_v      <= s1_v;
      s2_k      <= s1_k;
      s2_b2     <= b2_c;
      s2_b3     <= b3_c;
      s2_c      <= s1_c;
      s2_c3     <= c3_c;
      s2_hi     <= s1_hi;
      out_valid <= s2_v;
      out_data  <= OUT_BITS'(w_q);
      out_index <= s2_k;
      out_last  <= s2_v && (s2_k == K_LAST);
    end
  end

endmodule

// File: tb/tb_parzen_window_gen.sv
// Directed bench for parzen_window_gen at L=16, Q1.16: window values, latency,
// frame control, backpressure, stop, ignored start and asynchronous reset.
module tb_parzen_window_gen;

  localparam int LP = 4;
  localparam int FB = 16;
  localparam int OB = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic          continuous;
  logic          stop;
  logic [OB-1:0] out_data;
  logic [LP-1:0] out_index;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  parzen_window_gen #(.LEN_POW2(LP), .FRAC_BITS(FB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .continuous(continuous), .stop(stop), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [OB-1:0] rx_data[$];
  logic [LP-1:0] rx_index[$];
  logic          rx_last[$];
  logic [OB-1:0] exp_q[$];
  int            done_count;
  int            stall_errs;
  int            extra_valid;
  bit            timed_out;
  logic          busy_at_done;

  // Hand-computed window values for L=16 (H=8), indexed by a = |k-8|.
  function automatic logic [OB-1:0] exp_w(input logic [1:0] m, input int k);
    int a;
    logic [OB-1:0] r;
    a = (k >= 8) ? k - 8 : 8 - k;
    r = '0;
    case (m)
      2'd0: r = 17'h10000;
      2'd1: r = OB'(65536 - a * 8192);
      default: begin
        case (a)
          0: r = 17'h10000;
          1: r = 17'h0EB00;
          2: r = 17'h0B800;
          3: r = 17'h07900;
          4: r = 17'h04000;
          5: r = 17'h01B00;
          6: r = 17'h00800;
          7: r = 17'h00100;
          default: r = 17'h00000;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic start_frame(input logic [1:0] m, input logic c);
    mode = m; continuous = c; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_first_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drives out_ready, records transfers, notes stall instability, then watches a tail.
  task automatic run_stream(input int max_cycles, input bit rand_ready,
                            input int stop_frame, input int disturb_cycle);
    logic [OB-1:0] hold_data;
    logic [LP-1:0] hold_index;
    logic          hold_last;
    bit            stalled, got_done, stop_sent;
    int            frame;
    rx_data.delete(); rx_index.delete(); rx_last.delete();
    done_count = 0; stall_errs = 0; extra_valid = 0; timed_out = 0; busy_at_done = 1'b1;
    stalled = 0; got_done = 0; stop_sent = 0; frame = 1;
    hold_data = '0; hold_index = '0; hold_last = 1'b0;
    for (int cyc = 0; cyc < max_cycles && !got_done; cyc++) begin
      if (stalled && (!out_valid || out_data !== hold_data ||
                      out_index !== hold_index || out_last !== hold_last))
        stall_errs++;
      if (done) begin
        got_done = 1; done_count++; busy_at_done = busy;
      end else begin
        start = 1'b0; stop = 1'b0;
        if (cyc == disturb_cycle) begin start = 1'b1; mode = 2'd0; continuous = 1'b1; end
        if (stop_frame != 0 && !stop_sent && frame == stop_frame &&
            out_valid && out_index == LP'(5)) begin
          stop = 1'b1; stop_sent = 1;
        end
        out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        stalled = out_valid && !out_ready;
        if (out_valid && out_ready) begin
          rx_data.push_back(out_data);
          rx_index.push_back(out_index);
          rx_last.push_back(out_last);
          if (out_last) frame++;
        end else if (out_valid) begin
          hold_data = out_data; hold_index = out_index; hold_last = out_last;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    timed_out = !got_done;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_count++;
      if (out_valid) extra_valid++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_index !== '0) begin failures++; $display("FAIL reset_index got=%0d want=0", out_index); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_parzen_oneshot();
    int lat;
    start_frame(2'd2, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL parzen_busy_rise got=%b want=1", busy); end
    wait_first_valid(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL parzen_latency got=%0d want=3", lat); end
    run_stream(100, 1'b0, 0, -1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_w(2'd2, i));
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL parzen_timeout got=%b want=0", timed_out); end
    checks++; if (rx_data.size() !== 16) begin failures++; $display("FAIL parzen_count got=%0d want=16", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_index[i] !== LP'(i) || rx_last[i] !== (i == 15)) begin
        failures++;
        $display("FAIL parzen_sample i=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, rx_data[i], rx_index[i], rx_last[i], exp_q[i], i, (i == 15));
      end
    end
    if (rx_data.size() == 16) begin
      for (int j = 1; j < 8; j++) begin
        checks++;
        if (rx_data[8 + j] !== rx_data[8 - j]) begin
          failures++;
          $display("FAIL parzen_symmetry j=%0d got w[8+j]=%h want w[8-j]=%h", j, rx_data[8 + j], rx_data[8 - j]);
        end
      end
    end
    checks++; if (done_count !== 1) begin failures++; $display("FAIL parzen_done_pulses got=%0d want=1", done_count); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL parzen_busy_drop got=%b want=0", busy_at_done); end
    checks++; if (extra_valid !== 0) begin failures++; $display("FAIL parzen_extra_valid got=%0d want=0", extra_valid); end
  endtask

  task automatic test_triangular();
    int lat;
    start_frame(2'd1, 1'b0);
    wait_first_valid(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL tri_latency got=%0d want=3", lat); end
    run_stream(100, 1'b0, 0, -1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_w(2'd1, i));
    checks++; if (rx_data.size() !== 16 || timed_out) begin failures++; $display("FAIL tri_count got=%0d timeout=%b want=16 0", rx_data.size(), timed_out); end
    for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_index[i] !== LP'(i)) begin
        failures++;
        $display("FAIL tri_sample i=%0d got data=%h idx=%0d want data=%h idx=%0d", i, rx_data[i], rx_index[i], exp_q[i], i);
      end
    end
    checks++; if (done_count !== 1) begin failures++; $display("FAIL tri_done_pulses got=%0d want=1", done_count); end
  endtask

  task automatic test_rectangular();
    int lat;
    start_frame(2'd0, 1'b0);
    wait_first_valid(lat);
    run_stream(100, 1'b0, 0, -1);
    checks++; if (rx_data.size() !== 16 || timed_out) begin failures++; $display("FAIL rect_count got=%0d timeout=%b want=16 0", rx_data.size(), timed_out); end
    for (int i = 0; i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== 17'h10000 || rx_index[i] !== LP'(i)) begin
        failures++;
        $display("FAIL rect_sample i=%0d got data=%h idx=%0d want data=10000 idx=%0d", i, rx_data[i], rx_index[i], i);
      end
    end
  endtask

  task automatic test_continuous_stall();
    int lat;
    start_frame(2'd2, 1'b1);
    wait_first_valid(lat);
    run_stream(2000, 1'b1, 2, -1);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_w(2'd2, i % 16));
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL cont_timeout got=%b want=0", timed_out); end
    checks++; if (rx_data.size() !== 32) begin failures++; $display("FAIL cont_count got=%0d want=32", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_index[i] !== LP'(i % 16) || rx_last[i] !== ((i % 16) == 15)) begin
        failures++;
        $display("FAIL cont_sample i=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, rx_data[i], rx_index[i], rx_last[i], exp_q[i], i % 16, ((i % 16) == 15));
      end
    end
    checks++; if (stall_errs !== 0) begin failures++; $display("FAIL cont_stall_stable got=%0d want=0", stall_errs); end
    checks++; if (done_count !== 1) begin failures++; $display("FAIL cont_done_pulses got=%0d want=1", done_count); end
    checks++; if (extra_valid !== 0) begin failures++; $display("FAIL cont_no_frame3 got=%0d want=0", extra_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_frame(2'd2, 1'b0);
    wait_first_valid(lat);
    run_stream(200, 1'b0, 0, 2);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_w(2'd2, i));
    checks++; if (rx_data.size() !== 16 || timed_out) begin failures++; $display("FAIL b2b_count got=%0d timeout=%b want=16 0", rx_data.size(), timed_out); end
    for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_index[i] !== LP'(i)) begin
        failures++;
        $display("FAIL b2b_sample i=%0d got data=%h idx=%0d want data=%h idx=%0d", i, rx_data[i], rx_index[i], exp_q[i], i);
      end
    end
    checks++; if (done_count !== 1 || extra_valid !== 0) begin failures++; $display("FAIL b2b_single_run got done=%0d extra=%0d want 1 0", done_count, extra_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int n, lat, dn, vn;
    start_frame(2'd2, 1'b0);
    n = 0;
    while (!(out_valid && out_index == LP'(7)) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n >= 50) begin failures++; $display("FAIL rstmid_reach_k7 got cycles=%0d want <50", n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got valid=%b data=%h idx=%0d last=%b busy=%b done=%b want all 0",
               out_valid, out_data, out_index, out_last, busy, done);
    end
    dn = 0; vn = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (out_valid) vn++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (out_valid) vn++;
    end
    checks++; if (dn !== 0 || vn !== 0) begin failures++; $display("FAIL rstmid_no_done got done=%0d valid=%0d want 0 0", dn, vn); end
    start_frame(2'd2, 1'b0);
    wait_first_valid(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rstmid_restart_latency got=%0d want=3", lat); end
    run_stream(100, 1'b0, 0, -1);
    checks++; if (rx_data.size() !== 16 || timed_out) begin failures++; $display("FAIL rstmid_count got=%0d timeout=%b want=16 0", rx_data.size(), timed_out); end
    for (int i = 0; i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_w(2'd2, i) || rx_index[i] !== LP'(i)) begin
        failures++;
        $display("FAIL rstmid_sample i=%0d got data=%h idx=%0d want data=%h idx=%0d", i, rx_data[i], rx_index[i], exp_w(2'd2, i), i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; continuous = 1'b0; stop = 1'b0; out_ready = 1'b1;
    test_reset();
    test_parzen_oneshot();
    test_triangular();
    test_rectangular();
    test_continuous_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
